// File: rtl/axi4lite_mem_slave_if.sv
// AXI4-Lite bus bundle between a master and the memory responder.
// The master drives requests and the ready signals for responses; the slave drives the rest.
interface axi4lite_mem_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite responder over a word-addressed synchronous RAM with byte strobes.
// Independent read and write FSMs; accesses outside the window answer SLVERR.
module axi4lite_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                clk,
  input  logic                rst,
  axi4lite_mem_slave_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} rstate_t;

  // Subtraction wraps below BASE_ADDR, so the lower-bound compare is kept explicit.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (IDX_W + 2)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  wstate_t               wstate_reg, wstate_next;
  rstate_t               rstate_reg, rstate_next;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            wstrb_reg;
  logic [ADDR_WIDTH-1:0] raddr_reg;
  logic [1:0]            bresp_reg;
  logic [1:0]            rresp_reg;
  logic                  rd_ok_reg;
  logic [31:0]           rd_word;

  logic aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;
  logic aw_hs, w_hs, ar_hs;
  logic w_ok, r_ok, do_write, do_read;
  logic [IDX_W-1:0] widx, ridx;

  assign aw_hs    = bus.awvalid && aw_rdy;
  assign w_hs     = bus.wvalid  && w_rdy;
  assign ar_hs    = bus.arvalid && ar_rdy;
  assign w_ok     = addr_ok(waddr_reg);
  assign r_ok     = addr_ok(raddr_reg);
  assign widx     = addr_idx(waddr_reg);
  assign ridx     = addr_idx(raddr_reg);
  assign do_write = (wstate_reg == W_COMMIT) && w_ok;
  assign do_read  = (rstate_reg == R_READ);

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wstate_reg <= W_IDLE;
    else      wstate_reg <= wstate_next;
  end

  always_comb begin
    wstate_next = wstate_reg;
    case (wstate_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_next = W_COMMIT;
        else if (aw_hs)    wstate_next = W_WAIT_DATA;
        else if (w_hs)     wstate_next = W_WAIT_ADDR;
      end
      W_WAIT_DATA: if (w_hs)       wstate_next = W_COMMIT;
      W_WAIT_ADDR: if (aw_hs)      wstate_next = W_COMMIT;
      W_COMMIT:                    wstate_next = W_RESP;
      W_RESP:      if (bus.bready) wstate_next = W_IDLE;
      default:                     wstate_next = W_IDLE;
    endcase
  end

  // Readys are gated by rst so nothing is accepted while reset is held.
  always_comb begin
    aw_rdy = rst && ((wstate_reg == W_IDLE) || (wstate_reg == W_WAIT_ADDR));
    w_rdy  = rst && ((wstate_reg == W_IDLE) || (wstate_reg == W_WAIT_DATA));
    b_vld  = (wstate_reg == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (aw_hs) waddr_reg <= bus.awaddr;
    if (w_hs) begin
      wdata_reg <= bus.wdata;
      wstrb_reg <= bus.wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         bresp_reg <= RESP_OKAY;
    else if (wstate_reg == W_COMMIT)  bresp_reg <= w_ok ? RESP_OKAY : RESP_SLVERR;
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rstate_reg <= R_IDLE;
    else      rstate_reg <= rstate_next;
  end

  always_comb begin
    rstate_next = rstate_reg;
    case (rstate_reg)
      R_IDLE:  if (ar_hs)      rstate_next = R_READ;
      R_READ:                  rstate_next = R_DATA;
      R_DATA:  if (bus.rready) rstate_next = R_IDLE;
      default:                 rstate_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_rdy = rst && (rstate_reg == R_IDLE);
    r_vld  = (rstate_reg == R_DATA);
  end

  always_ff @(posedge clk) begin
    if (ar_hs) raddr_reg <= bus.araddr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rresp_reg <= RESP_OKAY;
      rd_ok_reg <= 1'b0;
    end else if (do_read) begin
      rresp_reg <= r_ok ? RESP_OKAY : RESP_SLVERR;
      rd_ok_reg <= r_ok;
    end
  end

  // ---------------- RAM, one byte-wide array per lane ----------------
  // Read and write share an edge, so a same-word collision reads the old data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (do_write && wstrb_reg[gi]) mem[widx] <= wdata_reg[8*gi +: 8];
      if (do_read)                   q <= mem[ridx];
    end

    assign rd_word[8*gi +: 8] = q;
  end

  // rd_ok_reg clears on reset and on out-of-range reads, forcing rdata to zero.
  assign bus.awready = aw_rdy;
  assign bus.wready  = w_rdy;
  assign bus.bvalid  = b_vld;
  assign bus.bresp   = bresp_reg;
  assign bus.arready = ar_rdy;
  assign bus.rvalid  = r_vld;
  assign bus.rresp   = rresp_reg;
  assign bus.rdata   = rd_ok_reg ? rd_word : 32'h0;
endmodule

// File: doc/axi4lite_mem_slave.md
Name: axi4lite_mem_slave

Overview:
AXI4-Lite responder backed by a word-addressed synchronous RAM. It is the memory-side endpoint for the core's AXI4-Lite instruction and data ports (insmemory/datamemory side of the bus). Read and write channels run independently. Byte-lane strobes are supported, and out-of-range accesses return SLVERR.

Parameters:
ADDR_WIDTH, 32, byte-address width of awaddr/araddr
DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of 2)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word-aligned)

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  asynchronous, active-low reset
awaddr  input  ADDR_WIDTH  write address
awvalid  input  1  write address valid
awready  output  1  write address accepted
wdata  input  32  write data
wstrb  input  4  byte-lane enables; bit i covers wdata[8i+7:8i]
wvalid  input  1  write data valid
wready  output  1  write data accepted
bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
bvalid  output  1  write response valid
bready  input  1  write response accepted
araddr  input  ADDR_WIDTH  read address
arvalid  input  1  read address valid
arready  output  1  read address accepted
rdata  output  32  read data
rresp  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR
rvalid  output  1  read data valid
rready  input  1  read data accepted

Behaviour:
- Reset (rst=0, asynchronous): write FSM goes to W_IDLE, read FSM to R_IDLE.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - awready/wready/arready forced 0 while rst=0.
  - RAM contents are not reset.
- Address decode:
  - In range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS.
  - Word index = (addr-BASE_ADDR)>>2; addr[1:0] ignored.
- Write FSM states: W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_COMMIT, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - AW and W both handshake on the same edge -> W_COMMIT.
    - AW only -> latch address, go to W_WAIT_DATA.
    - W only -> latch data and strb, go to W_WAIT_ADDR.
  - W_WAIT_DATA: awready=0, wready=1. On W handshake -> W_COMMIT.
  - W_WAIT_ADDR: awready=1, wready=0. On AW handshake -> W_COMMIT.
  - W_COMMIT: both readys 0.
    - In range: write the enabled byte lanes only; set bresp=OKAY.
    - Out of range: RAM untouched; set bresp=SLVERR.
    - Go to W_RESP.
  - W_RESP: bvalid=1, bresp held stable. On bready=1 -> W_IDLE, bvalid drops next cycle.
  - Latency: from the edge completing both handshakes to bvalid=1 is 2 edges.
  - Throughput: at most one write per 3 cycles.
- Read FSM states: R_IDLE, R_READ, R_DATA.
  - R_IDLE: arready=1. On AR handshake -> latch address, go to R_READ.
  - R_READ: arready=0. Perform the synchronous RAM read.
    - In range: rdata=RAM[index], rresp=OKAY.
    - Out of range: rdata=0, rresp=SLVERR.
    - Go to R_DATA.
  - R_DATA: rvalid=1; rdata/rresp held stable until rready=1, then -> R_IDLE.
  - Latency: rvalid rises 2 edges after the AR handshake edge.
- Simultaneous read and write:
  - The channels are independent.
  - If a W_COMMIT write and an R_READ read hit the same word on the same edge, the read returns the pre-write data.
- Backpressure:
  - No new AW/W/AR is accepted while a response is pending.
  - valid/data outputs must not change while valid=1 and ready=0.
- wstrb=4'h0 with an in-range address: no RAM change, bresp=OKAY.
- Reset mid-operation:
  - Any in-flight transaction is aborted; no response is issued.
  - A write already performed in W_COMMIT remains in RAM.
  - No partial write ever occurs.

Test Plan:
- Word write/read: AW 0x10 with W 0xDEADBEEF, strb 4'hF, same cycle -> bvalid 2 edges later, bresp=00. Then AR 0x10 -> rvalid 2 edges later, rdata=0xDEADBEEF, rresp=00.
- Byte strobe: write 0x0000AA00, strb 4'h2 to 0x10 -> subsequent read returns 0xDEADAAEF.
- Channel ordering: W arrives 3 cycles before AW (addr 0x20, data 0x12345678) -> wready drops after the W handshake, exactly one write occurs, read of 0x20 returns 0x12345678. Repeat with AW first: same result.
- Backpressure: hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout. Hold rready=0 likewise -> rdata stable, arready=0.
- Out of range: write and read at BASE_ADDR+4*DEPTH_WORDS -> bresp=10, rresp=10, rdata=0, and RAM word 0 is unchanged.
- Reset: assert rst=0 while in R_DATA -> rvalid goes 0 immediately (asynchronously). After release, arready=1 and a fresh read of 0x10 returns the last committed data.
